// File: rtl/vga_fb_fetch_sched_if.sv
// Memory read-request port between the framebuffer fetch scheduler and the shared framebuffer.
// One burst outstanding at a time; beats are returned on mem_rvalid.
interface vga_fb_fetch_sched_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 5
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [LEN_W-1:0]  mem_len;
    logic              mem_ack;
    logic              mem_rvalid;

    modport master (
        output mem_req, mem_addr, mem_len,
        input  mem_ack, mem_rvalid
    );

    modport slave (
        input  mem_req, mem_addr, mem_len,
        output mem_ack, mem_rvalid
    );
endinterface

// File: rtl/vga_fb_fetch_sched.sv
// Framebuffer fetch scheduler: walks the active frame linearly in bursts, gated on pixel FIFO room.
// state | meaning
// IDLE  | no frame in progress
// CHECK | compute next burst length, wait for FIFO room or end of frame
// REQ   | request held on the memory port until accepted
// DATA  | returned beats written into the pixel FIFO
// DRAIN | beats of an aborted burst discarded, then restart from pixel 0
module vga_fb_fetch_sched #(
    parameter int                HDISP      = 800,
    parameter int                VDISP      = 480,
    parameter int                BURST      = 16,
    parameter int                FIFO_DEPTH = 256,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                            pixel_clk,
    input  logic                            pixel_rst,
    input  logic                            frame_start,
    input  logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    vga_fb_fetch_sched_if.master            mem,
    output logic                            fifo_wr,
    output logic                            fifo_flush,
    output logic                            busy,
    output logic                            frame_late
);
    localparam int TOTAL = HDISP * VDISP;
    localparam int PIX_W = $clog2(TOTAL + 1);
    localparam int LEN_W = $clog2(BURST) + 1;
    localparam logic [PIX_W-1:0] TOTAL_P = PIX_W'(TOTAL);

    typedef enum logic [2:0] {IDLE, CHECK, REQ, DATA, DRAIN} state_t;

    state_t            state;
    logic [PIX_W-1:0]  pix_idx;
    logic [LEN_W-1:0]  beats_left;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] addr_q;
    logic              req_q;
    logic              abort_q;

    logic [31:0]       remaining;
    logic [LEN_W-1:0]  len_next;
    logic              fits;
    logic              last_beat;
    logic              final_beat;

    always_comb begin
        remaining  = 32'(TOTAL_P - pix_idx);
        len_next   = (remaining < 32'(BURST)) ? LEN_W'(remaining) : LEN_W'(BURST);
        fits       = (32'(fifo_level) + 32'(len_next)) <= 32'(FIFO_DEPTH);
        last_beat  = (beats_left == LEN_W'(1));
        final_beat = last_beat && ((pix_idx + PIX_W'(1)) == TOTAL_P);
    end

    // A late frame_start discards the coincident beat unless it completes the frame.
    assign fifo_wr       = (state == DATA) && mem.mem_rvalid && !(frame_start && !final_beat);
    assign busy          = (state != IDLE);
    assign mem.mem_req   = req_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_len   = len_q;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state      <= IDLE;
            pix_idx    <= '0;
            beats_left <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            req_q      <= 1'b0;
            abort_q    <= 1'b0;
            fifo_flush <= 1'b0;
            frame_late <= 1'b0;
        end else begin
            fifo_flush <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        pix_idx    <= '0;
                        fifo_flush <= 1'b1;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (frame_start) begin
                        if (pix_idx != TOTAL_P) frame_late <= 1'b1;
                        pix_idx    <= '0;
                        fifo_flush <= 1'b1;
                    end else if (pix_idx == TOTAL_P) begin
                        state <= IDLE;
                    end else if (fits) begin
                        req_q  <= 1'b1;
                        addr_q <= BASE_ADDR + (ADDR_W'(pix_idx) << 2);
                        len_q  <= len_next;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (frame_start) begin
                        frame_late <= 1'b1;
                        abort_q    <= 1'b1;
                    end
                    if (mem.mem_ack) begin
                        req_q      <= 1'b0;
                        beats_left <= len_q;
                        abort_q    <= 1'b0;
                        state      <= (abort_q || frame_start) ? DRAIN : DATA;
                    end
                end
                DATA: begin
                    if (frame_start && !(mem.mem_rvalid && final_beat)) frame_late <= 1'b1;
                    if (mem.mem_rvalid && last_beat) begin
                        beats_left <= '0;
                        if (frame_start) begin
                            pix_idx    <= '0;
                            fifo_flush <= 1'b1;
                        end else begin
                            pix_idx <= pix_idx + PIX_W'(1);
                        end
                        state <= CHECK;
                    end else if (mem.mem_rvalid) begin
                        beats_left <= beats_left - LEN_W'(1);
                        if (frame_start) state <= DRAIN;
                        else pix_idx <= pix_idx + PIX_W'(1);
                    end else if (frame_start) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem.mem_rvalid) begin
                        beats_left <= beats_left - LEN_W'(1);
                        if (last_beat) begin
                            pix_idx    <= '0;
                            fifo_flush <= 1'b1;
                            state      <= CHECK;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_fb_fetch_sched.sv
// Directed bench for vga_fb_fetch_sched on a 4x2 frame, burst 3, FIFO depth 8, base 0x100.
module tb_vga_fb_fetch_sched;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 3;
    localparam int LVL_W  = 4;

    logic             pixel_clk = 1'b0;
    logic             pixel_rst = 1'b1;
    logic             frame_start = 1'b0;
    logic [LVL_W-1:0] fifo_level = '0;
    logic             fifo_wr, fifo_flush, busy, frame_late;

    vga_fb_fetch_sched_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) mem_if ();

    vga_fb_fetch_sched #(
        .HDISP(4), .VDISP(2), .BURST(3), .FIFO_DEPTH(8), .ADDR_W(ADDR_W), .BASE_ADDR(32'h100)
    ) dut (
        .pixel_clk  (pixel_clk),
        .pixel_rst  (pixel_rst),
        .frame_start(frame_start),
        .fifo_level (fifo_level),
        .mem        (mem_if.master),
        .fifo_wr    (fifo_wr),
        .fifo_flush (fifo_flush),
        .busy       (busy),
        .frame_late (frame_late)
    );

    always #5 pixel_clk = ~pixel_clk;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          wr_cnt = 0;
    int          flush_cnt = 0;
    int          req_n = 0;
    logic [31:0] req_addr [64];
    int          req_len  [64];

    // Inputs change just after the rising edge, so the falling edge sees a settled cycle.
    always @(negedge pixel_clk) begin
        if (fifo_wr) wr_cnt++;
        if (fifo_flush) flush_cnt++;
        if (mem_if.mem_req && mem_if.mem_ack && req_n < 64) begin
            req_addr[req_n] = mem_if.mem_addr;
            req_len[req_n]  = int'(mem_if.mem_len);
            req_n++;
        end
    end

    task automatic tick;
        @(posedge pixel_clk);
        #2;
    endtask

    task automatic do_reset;
        pixel_rst          = 1'b1;
        frame_start        = 1'b0;
        fifo_level         = '0;
        mem_if.mem_ack     = 1'b0;
        mem_if.mem_rvalid  = 1'b0;
        tick;
        tick;
        pixel_rst = 1'b0;
        tick;
    endtask

    task automatic pulse_start;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_if.mem_req) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    task automatic serve_burst(input int ack_delay, output bit ok);
        int n;
        wait_req(ok);
        if (ok) begin
            repeat (ack_delay) tick;
            n = int'(mem_if.mem_len);
            mem_if.mem_ack = 1'b1;
            tick;
            mem_if.mem_ack = 1'b0;
            for (int i = 0; i < n; i++) begin
                mem_if.mem_rvalid = 1'b1;
                tick;
            end
            mem_if.mem_rvalid = 1'b0;
        end
    endtask

    task automatic test_reset;
        pixel_rst = 1'b1;
        mem_if.mem_ack = 1'b0;
        mem_if.mem_rvalid = 1'b1;
        tick;
        chk_cnt++;
        if ({mem_if.mem_req, fifo_wr, fifo_flush, busy, frame_late} !== 5'b0)
            $display("FAIL reset_flags: got %b exp 00000",
                     {mem_if.mem_req, fifo_wr, fifo_flush, busy, frame_late});
        else pass_cnt++;
        chk_cnt++;
        if ({mem_if.mem_addr, mem_if.mem_len} !== {32'h0, 3'd0})
            $display("FAIL reset_addr_len: got %h/%0d exp 0/0", mem_if.mem_addr, mem_if.mem_len);
        else pass_cnt++;
        pixel_rst = 1'b0;
        tick;
        #1;
        chk_cnt++;
        if (fifo_wr !== 1'b0) $display("FAIL idle_rvalid_ignored: fifo_wr got %b exp 0", fifo_wr);
        else pass_cnt++;
        mem_if.mem_rvalid = 1'b0;
    endtask

    task automatic test_full_frame;
        logic [31:0] exp_addr [3];
        int          exp_len  [3];
        int w0, f0, r0;
        bit ok, ok_all;
        exp_addr = '{32'h100, 32'h10C, 32'h118};
        exp_len  = '{3, 3, 2};
        do_reset;
        w0 = wr_cnt; f0 = flush_cnt; r0 = req_n;
        pulse_start;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL frame_busy_rise: got %b exp 1", busy);
        else pass_cnt++;
        ok_all = 1'b1;
        repeat (3) begin
            serve_burst(0, ok);
            ok_all &= ok;
        end
        chk_cnt++;
        if (!ok_all) $display("FAIL frame_req_timeout: got no request exp 3 requests");
        else pass_cnt++;
        repeat (3) tick;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL frame_busy_fall: got %b exp 0", busy);
        else pass_cnt++;
        chk_cnt++;
        if (req_n - r0 !== 3) $display("FAIL frame_req_count: got %0d exp 3", req_n - r0);
        else pass_cnt++;
        if (req_n - r0 >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk_cnt++;
                if (req_addr[r0+i] !== exp_addr[i] || req_len[r0+i] !== exp_len[i])
                    $display("FAIL frame_req%0d: got %h/%0d exp %h/%0d", i,
                             req_addr[r0+i], req_len[r0+i], exp_addr[i], exp_len[i]);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (wr_cnt - w0 !== 8) $display("FAIL frame_fifo_wr: got %0d exp 8", wr_cnt - w0);
        else pass_cnt++;
        chk_cnt++;
        if (flush_cnt - f0 !== 1) $display("FAIL frame_flush: got %0d exp 1", flush_cnt - f0);
        else pass_cnt++;
    endtask

    task automatic test_ack_delay;
        bit ok;
        do_reset;
        pulse_start;
        wait_req(ok);
        chk_cnt++;
        if (!ok) $display("FAIL ackdly_req_timeout: got no request exp request");
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++;
            if ({mem_if.mem_req, mem_if.mem_addr, mem_if.mem_len} !== {1'b1, 32'h100, 3'd3})
                $display("FAIL ackdly_hold%0d: got %b/%h/%0d exp 1/100/3", i,
                         mem_if.mem_req, mem_if.mem_addr, mem_if.mem_len);
            else pass_cnt++;
            tick;
        end
        mem_if.mem_ack = 1'b1;
        tick;
        mem_if.mem_ack = 1'b0;
        chk_cnt++;
        if (mem_if.mem_req !== 1'b0) $display("FAIL ackdly_drop: got %b exp 0", mem_if.mem_req);
        else pass_cnt++;
        repeat (3) begin
            mem_if.mem_rvalid = 1'b1;
            tick;
        end
        mem_if.mem_rvalid = 1'b0;
        wait_req(ok);
        chk_cnt++;
        if ({mem_if.mem_addr, mem_if.mem_len} !== {32'h10C, 3'd3})
            $display("FAIL ackdly_next_req: got %h/%0d exp 10c/3", mem_if.mem_addr, mem_if.mem_len);
        else pass_cnt++;
    endtask

    task automatic test_fifo_space;
        do_reset;
        fifo_level = 4'd6;
        pulse_start;
        for (int i = 0; i < 6; i++) begin
            chk_cnt++;
            if (mem_if.mem_req !== 1'b0) $display("FAIL space_block%0d: mem_req got %b exp 0", i, mem_if.mem_req);
            else pass_cnt++;
            tick;
        end
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL space_busy: got %b exp 1", busy);
        else pass_cnt++;
        fifo_level = 4'd5;
        tick;
        chk_cnt++;
        if ({mem_if.mem_req, mem_if.mem_addr, mem_if.mem_len} !== {1'b1, 32'h100, 3'd3})
            $display("FAIL space_release: got %b/%h/%0d exp 1/100/3",
                     mem_if.mem_req, mem_if.mem_addr, mem_if.mem_len);
        else pass_cnt++;
    endtask

    task automatic test_late_start;
        int w0, f0;
        bit ok;
        do_reset;
        pulse_start;
        serve_burst(0, ok);
        wait_req(ok);
        chk_cnt++;
        if (!ok || {mem_if.mem_addr, mem_if.mem_len} !== {32'h10C, 3'd3})
            $display("FAIL late_second_req: got %b %h/%0d exp 1 10c/3", ok, mem_if.mem_addr, mem_if.mem_len);
        else pass_cnt++;
        mem_if.mem_ack = 1'b1;
        tick;
        mem_if.mem_ack = 1'b0;
        w0 = wr_cnt; f0 = flush_cnt;
        mem_if.mem_rvalid = 1'b1;
        tick;
        mem_if.mem_rvalid = 1'b0;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        chk_cnt++;
        if (frame_late !== 1'b1) $display("FAIL late_flag: got %b exp 1", frame_late);
        else pass_cnt++;
        mem_if.mem_rvalid = 1'b1;
        tick;
        tick;
        mem_if.mem_rvalid = 1'b0;
        chk_cnt++;
        if (fifo_flush !== 1'b1) $display("FAIL late_flush_pulse: got %b exp 1", fifo_flush);
        else pass_cnt++;
        chk_cnt++;
        if (wr_cnt - w0 !== 1) $display("FAIL late_absorb: fifo_wr count got %0d exp 1", wr_cnt - w0);
        else pass_cnt++;
        wait_req(ok);
        chk_cnt++;
        if (!ok || {mem_if.mem_addr, mem_if.mem_len} !== {32'h100, 3'd3})
            $display("FAIL late_restart_req: got %b %h/%0d exp 1 100/3", ok, mem_if.mem_addr, mem_if.mem_len);
        else pass_cnt++;
        chk_cnt++;
        if (flush_cnt - f0 !== 1 || frame_late !== 1'b1)
            $display("FAIL late_sticky: flushes got %0d late %b exp 1 1", flush_cnt - f0, frame_late);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst;
        bit ok;
        do_reset;
        pulse_start;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        chk_cnt++;
        if (frame_late !== 1'b1) $display("FAIL rstmid_late_set: got %b exp 1", frame_late);
        else pass_cnt++;
        wait_req(ok);
        mem_if.mem_ack = 1'b1;
        tick;
        mem_if.mem_ack = 1'b0;
        mem_if.mem_rvalid = 1'b1;
        #1;
        chk_cnt++;
        if (!ok || fifo_wr !== 1'b1 || busy !== 1'b1)
            $display("FAIL rstmid_in_data: got req %b wr %b busy %b exp 1 1 1", ok, fifo_wr, busy);
        else pass_cnt++;
        pixel_rst = 1'b1;
        #1;
        chk_cnt++;
        if ({mem_if.mem_req, fifo_wr, fifo_flush, busy, frame_late} !== 5'b0)
            $display("FAIL rstmid_outputs: got %b exp 00000",
                     {mem_if.mem_req, fifo_wr, fifo_flush, busy, frame_late});
        else pass_cnt++;
        tick;
        pixel_rst = 1'b0;
        tick;
        tick;
        chk_cnt++;
        if ({mem_if.mem_req, fifo_wr, busy} !== 3'b0)
            $display("FAIL rstmid_idle: got %b exp 000", {mem_if.mem_req, fifo_wr, busy});
        else pass_cnt++;
        mem_if.mem_rvalid = 1'b0;
    endtask

    task automatic test_on_time_start;
        bit ok, ok_all;
        do_reset;
        pulse_start;
        serve_burst(0, ok);
        ok_all = ok;
        serve_burst(0, ok);
        ok_all &= ok;
        wait_req(ok);
        ok_all &= ok;
        chk_cnt++;
        if (!ok_all || {mem_if.mem_addr, mem_if.mem_len} !== {32'h118, 3'd2})
            $display("FAIL ontime_last_req: got %b %h/%0d exp 1 118/2", ok_all, mem_if.mem_addr, mem_if.mem_len);
        else pass_cnt++;
        mem_if.mem_ack = 1'b1;
        tick;
        mem_if.mem_ack = 1'b0;
        mem_if.mem_rvalid = 1'b1;
        tick;
        frame_start = 1'b1;
        #1;
        chk_cnt++;
        if (fifo_wr !== 1'b1) $display("FAIL ontime_final_write: got %b exp 1", fifo_wr);
        else pass_cnt++;
        tick;
        frame_start = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        chk_cnt++;
        if ({frame_late, fifo_flush, busy} !== 3'b011)
            $display("FAIL ontime_restart: late/flush/busy got %b exp 011", {frame_late, fifo_flush, busy});
        else pass_cnt++;
        wait_req(ok);
        chk_cnt++;
        if (!ok || {mem_if.mem_addr, mem_if.mem_len, frame_late} !== {32'h100, 3'd3, 1'b0})
            $display("FAIL ontime_new_frame: got %b %h/%0d late %b exp 1 100/3 0",
                     ok, mem_if.mem_addr, mem_if.mem_len, frame_late);
        else pass_cnt++;
    endtask

    initial begin
        mem_if.mem_ack    = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        test_reset;
        test_full_frame;
        test_ack_delay;
        test_fifo_space;
        test_late_start;
        test_reset_mid_burst;
        test_on_time_start;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1);
    end
endmodule
